// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes non-memory results straight to writeback and runs
// one outstanding req/ack data-memory transaction at a time for loads and stores.
// Optional feature macro: ALIGN_CHECK_EN adds a misalign output and suppresses
// misaligned half/word accesses.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic [31:0]          ALUresult,
  input  logic [31:0]          StoreData,
  input  logic [4:0]           WriteReg,
  input  logic                 RegWrite,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [1:0]           MemSize,
  input  logic                 MemSigned,
  input  logic                 overFlow,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic                 wb_valid,
  output logic                 wb_RegWrite,
  output logic [4:0]           wb_WriteReg,
  output logic [31:0]          wb_data,
  output logic                 wb_overflow,
  output logic [TIMEOUT_W-1:0] wait_cycles
`ifdef ALIGN_CHECK_EN
  ,
  output logic                 misalign
`endif
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d, sgn_q, sgn_d, rw_q, rw_d, ovf_q, ovf_d;
  logic [1:0]            size_q, size_d, lane_q, lane_d;
  logic [4:0]            wreg_q, wreg_d;
  logic                  flushed_q, flushed_d;
  logic [TIMEOUT_W-1:0]  wait_q, wait_d;
  logic                  wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, wb_ovf_q, wb_ovf_d;
  logic [4:0]            wb_wreg_q, wb_wreg_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic                  misal_q, misal_d;

  logic                  accept, is_mem, misal;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata, ld_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign accept = in_valid & in_ready & ~flush;
  assign is_mem = MemRead | MemWrite;

`ifdef ALIGN_CHECK_EN
  // Half needs even address, word needs a fully aligned one.
  assign misal = is_mem & (((MemSize == 2'b01) & ALUresult[0]) |
                           (MemSize[1] & (ALUresult[1:0] != 2'b00)));
  assign misalign = misal_q;
`else
  assign misal = 1'b0;
`endif

  // Byte enables and lane-replicated store data from the incoming instruction.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = StoreData;
    case (MemSize)
      2'b00: begin
        st_be    = 4'b0001 << ALUresult[1:0];
        st_wdata = {4{StoreData[7:0]}};
      end
      2'b01: begin
        st_be    = ALUresult[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  // Select the addressed lane of read data and extend it.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state logic: acceptance in IDLE, completion and wait counting in BUSY.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    size_d     = size_q;
    lane_d     = lane_q;
    sgn_d      = sgn_q;
    rw_d       = rw_q;
    wreg_d     = wreg_q;
    ovf_d      = ovf_q;
    flushed_d  = flushed_q;
    wait_d     = wait_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = wb_rw_q;
    wb_wreg_d  = wb_wreg_q;
    wb_data_d  = wb_data_q;
    wb_ovf_d   = wb_ovf_q;
    misal_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mem && !misal) begin
            state_d   = StBusy;
            addr_d    = {ALUresult[31:2], 2'b00};
            wdata_d   = st_wdata;
            be_d      = st_be;
            we_d      = MemWrite;
            size_d    = MemSize;
            lane_d    = ALUresult[1:0];
            sgn_d     = MemSigned;
            rw_d      = RegWrite;
            wreg_d    = WriteReg;
            ovf_d     = overFlow;
            flushed_d = 1'b0;
            wait_d    = '0;
          end else begin
            wb_valid_d = 1'b1;
            wb_rw_d    = RegWrite & ~misal;
            wb_wreg_d  = WriteReg;
            wb_data_d  = ALUresult;
            wb_ovf_d   = overFlow;
            misal_d    = misal;
          end
        end
      end
      StBusy: begin
        if (mem_ack) begin
          state_d   = StIdle;
          flushed_d = 1'b0;
          // A flush seen at any point of the transaction kills its writeback.
          if (!(flushed_q || flush)) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = rw_q & ~we_q;
            wb_wreg_d  = wreg_q;
            wb_data_d  = ld_data;
            wb_ovf_d   = ovf_q;
          end
        end else begin
          flushed_d = flushed_q | flush;
          if (wait_q != {TIMEOUT_W{1'b1}}) wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      lane_q     <= '0;
      sgn_q      <= 1'b0;
      rw_q       <= 1'b0;
      wreg_q     <= '0;
      ovf_q      <= 1'b0;
      flushed_q  <= 1'b0;
      wait_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_wreg_q  <= '0;
      wb_data_q  <= '0;
      wb_ovf_q   <= 1'b0;
      misal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      size_q     <= size_d;
      lane_q     <= lane_d;
      sgn_q      <= sgn_d;
      rw_q       <= rw_d;
      wreg_q     <= wreg_d;
      ovf_q      <= ovf_d;
      flushed_q  <= flushed_d;
      wait_q     <= wait_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_data_q  <= wb_data_d;
      wb_ovf_q   <= wb_ovf_d;
      misal_q    <= misal_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign mem_req     = (state_q == StBusy);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_RegWrite = wb_rw_q;
  assign wb_WriteReg = wb_wreg_q;
  assign wb_data     = wb_data_q;
  assign wb_overflow = wb_ovf_q;
  assign wait_cycles = wait_q;

  // misal_q is only observable when the alignment check is built in.
  logic unused_misal;
  assign unused_misal = misal_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int TW = 8;

  logic clk, rst_n, in_valid, in_ready, flush;
  logic [31:0] ALUresult, StoreData;
  logic [4:0]  WriteReg;
  logic RegWrite, MemRead, MemWrite, MemSigned, overFlow;
  logic [1:0]  MemSize;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic wb_valid, wb_RegWrite, wb_overflow;
  logic [4:0]  wb_WriteReg;
  logic [31:0] wb_data;
  logic [TW-1:0] wait_cycles;
`ifdef ALIGN_CHECK_EN
  logic misalign;
`endif

  int passed = 0;
  int total  = 0;

  mem_access_stage #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .ALUresult(ALUresult), .StoreData(StoreData), .WriteReg(WriteReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
    .overFlow(overFlow), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg),
    .wb_data(wb_data), .wb_overflow(wb_overflow), .wait_cycles(wait_cycles)
`ifdef ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: access size arithmetic ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Byte offset of the accessed lane: address rounded down to the access size.
  function automatic int lane_off(input logic [1:0] sz, input logic [1:0] a);
    int o;
    o = a;
    return o - (o % nbytes(sz));
  endfunction

  function automatic logic [31:0] size_mask(input int n);
    return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] a);
    int b;
    b = ((1 << nbytes(sz)) - 1) << lane_off(sz, a);
    return b[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] sd);
    int n;
    logic [31:0] d, w;
    n = nbytes(sz);
    d = sd & size_mask(n);
    w = '0;
    for (int i = 0; i < 4 / n; i++) w = w | (d << (8 * n * i));
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic [1:0] a,
                                           input logic sgn, input logic [31:0] rd);
    int n;
    logic [31:0] v, m;
    n = nbytes(sz);
    m = size_mask(n);
    v = (rd >> (8 * lane_off(sz, a))) & m;
    if (sgn && n < 4 && v[8 * n - 1]) v = v | ~m;
    return v;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; ALUresult = '0; StoreData = '0; WriteReg = '0;
    RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemSize = '0; MemSigned = 1'b0;
    overFlow = 1'b0;
  endtask

  task automatic drive_instr(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sgn, input logic [31:0] alu, input logic [31:0] sd,
                             input logic [4:0] wreg, input logic rw, input logic ovf);
    in_valid = 1'b1; flush = 1'b0; MemRead = rd; MemWrite = wr; MemSize = sz;
    MemSigned = sgn; ALUresult = alu; StoreData = sd; WriteReg = wreg; RegWrite = rw;
    overFlow = ovf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    mem_ack = 1'b0; mem_rdata = '0;
    rst_n = 1'b0;
    #3;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else passed++;
    total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid); else passed++;
    total++; if (wb_data !== 32'h0) $display("FAIL reset_wb_data: got %h want 0", wb_data); else passed++;
    total++; if ({mem_be, mem_we, mem_addr, wait_cycles} !== '0)
      $display("FAIL reset_misc: got be=%b we=%b addr=%h wait=%0d want all 0",
               mem_be, mem_we, mem_addr, wait_cycles); else passed++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_rtype();
    drive_instr(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0007, 32'h0, 5'd5, 1'b1, 1'b1);
    step();
    idle_inputs();
    total++; if (wb_valid !== 1'b1) $display("FAIL rtype_valid: got %b want 1", wb_valid); else passed++;
    total++; if (wb_data !== 32'h7) $display("FAIL rtype_data: got %h want 7", wb_data); else passed++;
    total++; if (wb_WriteReg !== 5'd5) $display("FAIL rtype_reg: got %0d want 5", wb_WriteReg); else passed++;
    total++; if (wb_RegWrite !== 1'b1 || wb_overflow !== 1'b1)
      $display("FAIL rtype_flags: got rw=%b ovf=%b want 1 1", wb_RegWrite, wb_overflow); else passed++;
    total++; if (in_ready !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL rtype_ready: got rdy=%b req=%b want 1 0", in_ready, mem_req); else passed++;
    step();
    total++; if (wb_valid !== 1'b0) $display("FAIL rtype_pulse: got %b want 0", wb_valid); else passed++;
  endtask

  task automatic test_load_signed_byte();
    drive_instr(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 5'd9, 1'b1, 1'b0);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_req !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL lb_busy%0d: got req=%b rdy=%b want 1 0", i, mem_req, in_ready); else passed++;
      total++; if (mem_be !== 4'b1000 || mem_addr !== 32'h1000 || mem_we !== 1'b0)
        $display("FAIL lb_bus%0d: got be=%b addr=%h we=%b want 1000 1000 0",
                 i, mem_be, mem_addr, mem_we); else passed++;
      step();
    end
    mem_ack = 1'b1; mem_rdata = 32'h80FF_FFFF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    total++; if (wb_valid !== 1'b1) $display("FAIL lb_valid: got %b want 1", wb_valid); else passed++;
    total++; if (wb_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", wb_data); else passed++;
    total++; if (wait_cycles !== 8'd3) $display("FAIL lb_wait: got %0d want 3", wait_cycles); else passed++;
    total++; if (mem_req !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL lb_done: got req=%b rdy=%b want 0 1", mem_req, in_ready); else passed++;
    total++; if (wb_RegWrite !== 1'b1 || wb_WriteReg !== 5'd9)
      $display("FAIL lb_reg: got rw=%b reg=%0d want 1 9", wb_RegWrite, wb_WriteReg); else passed++;
  endtask

  task automatic test_store_half();
    drive_instr(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 5'd3, 1'b1, 1'b0);
    step();
    idle_inputs();
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1)
      $display("FAIL sh_req: got req=%b we=%b want 1 1", mem_req, mem_we); else passed++;
    total++; if (mem_be !== 4'b1100) $display("FAIL sh_be: got %b want 1100", mem_be); else passed++;
    total++; if (mem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata: got %h want abcdabcd", mem_wdata); else passed++;
    total++; if (mem_addr !== 32'h2000) $display("FAIL sh_addr: got %h want 2000", mem_addr); else passed++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0)
      $display("FAIL sh_wb: got valid=%b rw=%b want 1 0", wb_valid, wb_RegWrite); else passed++;
    total++; if (wait_cycles !== 8'd0) $display("FAIL sh_wait: got %0d want 0", wait_cycles); else passed++;
  endtask

  task automatic test_mem_random();
    logic rd, wr, sgn, rw;
    logic [1:0] sz, a;
    logic [31:0] alu, sd, rdat;
    logic [4:0] wreg;
    int op, dly, n;
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 2);
      rd = (op != 1); wr = (op != 0);
      sz = 2'($urandom_range(0, 3)); a = 2'($urandom_range(0, 3));
`ifdef ALIGN_CHECK_EN
      n = nbytes(sz);
      a = 2'(lane_off(sz, a));
`else
      n = 0;
`endif
      alu = {$urandom(), 2'b00} | 32'(a);
      sd = $urandom(); rdat = $urandom(); sgn = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1)); wreg = 5'($urandom_range(0, 31));
      dly = $urandom_range(0, 3) + n * 0;
      drive_instr(rd, wr, sz, sgn, alu, sd, wreg, rw, 1'b0);
      step();
      idle_inputs();
      total++; if (mem_req !== 1'b1 || wb_valid !== 1'b0)
        $display("FAIL rnd%0d_req: got req=%b valid=%b want 1 0", it, mem_req, wb_valid); else passed++;
      total++; if (mem_addr !== {alu[31:2], 2'b00} || mem_we !== wr)
        $display("FAIL rnd%0d_addr: got %h we=%b want %h we=%b", it, mem_addr, mem_we,
                 {alu[31:2], 2'b00}, wr); else passed++;
      total++; if (mem_be !== exp_be(sz, a))
        $display("FAIL rnd%0d_be: got %b want %b", it, mem_be, exp_be(sz, a)); else passed++;
      if (wr) begin
        total++; if (mem_wdata !== exp_wdata(sz, sd))
          $display("FAIL rnd%0d_wdata: got %h want %h", it, mem_wdata, exp_wdata(sz, sd)); else passed++;
      end
      for (int c = 0; c < dly; c++) step();
      total++; if (mem_req !== 1'b1 || mem_addr !== {alu[31:2], 2'b00})
        $display("FAIL rnd%0d_hold: got req=%b addr=%h", it, mem_req, mem_addr); else passed++;
      mem_ack = 1'b1; mem_rdata = rdat;
      step();
      mem_ack = 1'b0; mem_rdata = $urandom();
      total++; if (wb_valid !== 1'b1 || wb_RegWrite !== (rw & ~wr))
        $display("FAIL rnd%0d_wb: got valid=%b rw=%b want 1 %b", it, wb_valid, wb_RegWrite,
                 rw & ~wr); else passed++;
      total++; if (wait_cycles !== TW'(dly))
        $display("FAIL rnd%0d_wait: got %0d want %0d", it, wait_cycles, dly); else passed++;
      if (!wr) begin
        total++; if (wb_data !== exp_load(sz, a, sgn, rdat) || wb_WriteReg !== wreg)
          $display("FAIL rnd%0d_load: got %h reg=%0d want %h reg=%0d", it, wb_data, wb_WriteReg,
                   exp_load(sz, a, sgn, rdat), wreg); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] v, e;
    for (int i = 0; i < 8; i++) begin
      v = $urandom();
      exp_q.push_back(v);
      drive_instr(1'b0, 1'b0, 2'b00, 1'b0, v, 32'h0, 5'(i), 1'b1, 1'b0);
      step();
      e = exp_q.pop_front();
      total++; if (wb_valid !== 1'b1 || wb_data !== e || in_ready !== 1'b1)
        $display("FAIL b2b%0d: got valid=%b data=%h rdy=%b want 1 %h 1", i, wb_valid, wb_data,
                 in_ready, e); else passed++;
    end
    idle_inputs();
    step();
    total++; if (wb_valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", wb_valid); else passed++;
  endtask

  task automatic test_flush_idle();
    drive_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5'd1, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    idle_inputs();
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL flush_idle: got req=%b valid=%b want 0 0", mem_req, wb_valid); else passed++;
  endtask

  task automatic test_flush_busy();
    drive_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 5'd7, 1'b1, 1'b0);
    step();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (mem_req !== 1'b1 || wb_valid !== 1'b0)
      $display("FAIL flushb_hold1: got req=%b valid=%b want 1 0", mem_req, wb_valid); else passed++;
    step();
    total++; if (mem_req !== 1'b1) $display("FAIL flushb_hold2: got %b want 1", mem_req); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flushb_done: got req=%b valid=%b rdy=%b want 0 0 1", mem_req, wb_valid,
               in_ready); else passed++;
    drive_instr(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 5'd2, 1'b1, 1'b0);
    step();
    idle_inputs();
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h55)
      $display("FAIL flushb_next: got valid=%b data=%h want 1 55", wb_valid, wb_data); else passed++;
  endtask

  task automatic test_wait_saturate();
    int lim;
    lim = (1 << TW) - 1;
    drive_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 5'd4, 1'b1, 1'b0);
    step();
    idle_inputs();
    for (int c = 0; c < 100; c++) step();
    total++; if (wait_cycles !== TW'(100)) $display("FAIL wait_mid: got %0d want 100", wait_cycles); else passed++;
    for (int c = 0; c < 200; c++) step();
    total++; if (wait_cycles !== TW'(lim)) $display("FAIL wait_sat: got %0d want %0d", wait_cycles, lim); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h0;
    step();
    mem_ack = 1'b0;
    step();
    total++; if (wait_cycles !== TW'(lim) || mem_req !== 1'b0)
      $display("FAIL wait_hold: got %0d req=%b want %0d 0", wait_cycles, mem_req, lim); else passed++;
  endtask

  task automatic test_reset_mid();
    drive_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 5'd6, 1'b1, 1'b0);
    step();
    idle_inputs();
    total++; if (mem_req !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", mem_req); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid_async: got req=%b rdy=%b want 0 1", mem_req, in_ready); else passed++;
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (wb_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL rstmid_stray%0d: got valid=%b req=%b rdy=%b want 0 0 1", c, wb_valid,
                 mem_req, in_ready); else passed++;
    end
    mem_ack = 1'b0;
  endtask

`ifdef ALIGN_CHECK_EN
  task automatic test_misalign();
    drive_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 5'd8, 1'b1, 1'b0);
    step();
    idle_inputs();
    total++; if (mem_req !== 1'b0) $display("FAIL mis_req: got %b want 0", mem_req); else passed++;
    total++; if (misalign !== 1'b1 || wb_valid !== 1'b1 || wb_RegWrite !== 1'b0)
      $display("FAIL mis_wb: got mis=%b valid=%b rw=%b want 1 1 0", misalign, wb_valid,
               wb_RegWrite); else passed++;
    step();
    total++; if (misalign !== 1'b0 || wb_valid !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL mis_pulse: got mis=%b valid=%b req=%b want 0 0 0", misalign, wb_valid,
               mem_req); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_signed_byte();
    test_store_half();
    test_mem_random();
    test_back_to_back();
    test_flush_idle();
    test_flush_busy();
    test_wait_saturate();
    test_reset_mid();
`ifdef ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
